// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types, sizes and helpers for the 4-to-2 priority encoder
package prio_enc_pkg;

  localparam int N_LINES = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [N_LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [N_LINES-1:0] one;
    one = {{(N_LINES-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// rtl/prio_enc4.sv - combinational 4-line priority selector, direction set by PRIO_HIGH
module prio_enc4
  import prio_enc_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [N_LINES-1:0] pend_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               any_o
);

  always_comb begin
    code_o = '0;
    any_o  = |pend_i;
    if (PRIO_HIGH) begin
      if      (pend_i[3]) code_o = 2'd3;
      else if (pend_i[2]) code_o = 2'd2;
      else if (pend_i[1]) code_o = 2'd1;
      else                code_o = 2'd0;
    end else begin
      if      (pend_i[0]) code_o = 2'd0;
      else if (pend_i[1]) code_o = 2'd1;
      else if (pend_i[2]) code_o = 2'd2;
      else if (pend_i[3]) code_o = 2'd3;
      else                code_o = 2'd0;
    end
  end

endmodule

// File: rtl/prio_enc_4to2_hs.sv
// rtl/prio_enc_4to2_hs.sv - buffered 4-to-2 priority encoder with valid/ready output
// Overrun pulse on OVR is built only when PRIO_ENC_OVERRUN_EN is defined.
module prio_enc_4to2_hs
  import prio_enc_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic EN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic RDY,
  output logic A0,
  output logic A1,
  output logic VALID,
  output logic OVR
);

  logic [N_LINES-1:0] pend_q, pend_d, clr_mask, evt;
  logic [CODE_W-1:0]  code_q, code_d, sel_code;
  logic               valid_q, valid_d, sel_any, load;
  state_e             state_q, state_d;

  assign evt = EN ? {D3, D2, D1, D0} : '0;

  prio_enc4 #(.PRIO_HIGH(PRIO_HIGH)) u_sel (
    .pend_i (pend_q),
    .code_o (sel_code),
    .any_o  (sel_any)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = valid_q;
    load     = 1'b0;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sel_any) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (RDY) begin
          if (sel_any) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      code_d   = sel_code;
      valid_d  = 1'b1;
      clr_mask = onehot(sel_code);
    end
    // New events are ORed after the clear so a same-cycle re-trigger survives.
    pend_d = (pend_q & ~clr_mask) | evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign A0    = code_q[0];
  assign A1    = code_q[1];
  assign VALID = valid_q;

`ifdef PRIO_ENC_OVERRUN_EN
  logic ovr_q, ovr_d;

  assign ovr_d = |(evt & pend_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign OVR = ovr_q;
`else
  assign OVR = 1'b0;
`endif

endmodule

// File: tb/tb_prio_enc_4to2_hs.sv
// tb/tb_prio_enc_4to2_hs.sv - directed bench for both priority directions against a behavioural model
module tb_prio_enc_4to2_hs;

`ifdef PRIO_ENC_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] pend;
    logic       val;
    logic [1:0] code;
    logic       ovr;
  } mstate_t;

  logic       clk;
  logic       rst, en, rdy;
  logic [3:0] d;
  logic       a0_w [2];
  logic       a1_w [2];
  logic       valid_w [2];
  logic       ovr_w [2];
  mstate_t    m [2];
  int         seq_l [$];
  int         seq_h [$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         started = 1'b0;

  // Instance 0 gives D0 priority, instance 1 gives D3 priority.
  prio_enc_4to2_hs #(.PRIO_HIGH(1'b0)) dut_l (
    .clk(clk), .rst(rst), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .RDY(rdy), .A0(a0_w[0]), .A1(a1_w[0]), .VALID(valid_w[0]), .OVR(ovr_w[0])
  );

  prio_enc_4to2_hs #(.PRIO_HIGH(1'b1)) dut_h (
    .clk(clk), .rst(rst), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .RDY(rdy), .A0(a0_w[1]), .A1(a1_w[1]), .VALID(valid_w[1]), .OVR(ovr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int best(input int p, input logic [3:0] pv);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p == 1) ? 3 - i : i;
      if (pv[k]) return k;
    end
    return -1;
  endfunction

  // One clock of the abstract behaviour: hand out a code whenever the output slot is free or
  // being accepted, then merge this cycle's captured events into the pending set.
  function automatic mstate_t step(input mstate_t s, input int p, input logic r,
                                   input logic e, input logic [3:0] dv, input logic rd);
    mstate_t n;
    int      b;
    bit      lost;
    n = s;
    if (r) begin
      n = '0;
    end else begin
      lost = 1'b0;
      for (int k = 0; k < 4; k++) if (e && dv[k] && s.pend[k]) lost = 1'b1;
      if (!s.val || rd) begin
        b = best(p, s.pend);
        if (b >= 0) begin
          n.code    = b[1:0];
          n.val     = 1'b1;
          n.pend[b] = 1'b0;
        end else begin
          n.val = 1'b0;
        end
      end
      for (int k = 0; k < 4; k++) if (e && dv[k]) n.pend[k] = 1'b1;
      n.ovr = OVR_ON && lost;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= step(m[0], 0, rst, en, d, rdy);
    m[1] <= step(m[1], 1, rst, en, d, rdy);
    if (!rst && valid_w[0] === 1'b1 && rdy) seq_l.push_back({a1_w[0], a0_w[0]});
    if (!rst && valid_w[1] === 1'b1 && rdy) seq_h.push_back({a1_w[1], a0_w[1]});
  end

  always @(negedge clk) begin
    if (started) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("valid[%0d]", p), int'(valid_w[p]), int'(m[p].val));
        chk($sformatf("code[%0d]", p), int'({a1_w[p], a0_w[p]}), int'(m[p].code));
        chk($sformatf("ovr[%0d]", p), int'(ovr_w[p]), int'(m[p].ovr));
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [3:0] dv, input logic rd);
    rst = r;
    en  = e;
    d   = dv;
    rdy = rd;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int p, input int v, input int c);
    chk($sformatf("%s_valid[%0d]", name, p), int'(valid_w[p]), v);
    chk($sformatf("%s_code[%0d]", name, p), int'({a1_w[p], a0_w[p]}), c);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; d = 4'b1000; rdy = 1'b0;
    @(negedge clk);

    // Reset held with an event present
    drive(1'b1, 1'b1, 4'b1000, 1'b0);
    started = 1'b1;
    drive(1'b1, 1'b1, 4'b1000, 1'b0);
    for (int p = 0; p < 2; p++) begin
      lit("rst", p, 0, 0);
      chk($sformatf("rst_ovr[%0d]", p), int'(ovr_w[p]), 0);
    end
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    lit("post_rst", 1, 0, 0);

    // Single D2 event, held while RDY low, then accepted
    drive(1'b0, 1'b1, 4'b0100, 1'b0);
    lit("d2_lat1", 1, 0, 0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    lit("d2_lat2", 1, 1, 2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 1'b0);
      lit("d2_hold", 0, 1, 2);
    end
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    lit("d2_done", 1, 0, 2);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);

    // Three simultaneous events drained back-to-back
    seq_l.delete();
    seq_h.delete();
    drive(1'b0, 1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4'b0000, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    chk("burst_len_h", seq_h.size(), 3);
    chk("burst_len_l", seq_l.size(), 3);
    if (seq_h.size() == 3) begin
      chk("burst_h0", seq_h[0], 3);
      chk("burst_h1", seq_h[1], 1);
      chk("burst_h2", seq_h[2], 0);
    end
    if (seq_l.size() == 3) begin
      chk("burst_l0", seq_l[0], 0);
      chk("burst_l1", seq_l[1], 1);
      chk("burst_l2", seq_l[2], 3);
    end

    // Capture disabled
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'b1111, 1'b0);
      lit("en_off", 1, 0, 0);
    end
    drive(1'b0, 1'b1, 4'b0010, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    lit("en_on", 0, 1, 1);
    lit("en_on", 1, 1, 1);
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);

    // Repeat D1 while it is still pending behind a presented D3
    seq_l.delete();
    seq_h.delete();
    drive(1'b0, 1'b1, 4'b1000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 4'b0010, 1'b0);
    chk("ovr_first", int'(ovr_w[1]), 0);
    drive(1'b0, 1'b1, 4'b0010, 1'b0);
    chk("ovr_merge_h", int'(ovr_w[1]), int'(OVR_ON));
    chk("ovr_merge_l", int'(ovr_w[0]), int'(OVR_ON));
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    chk("ovr_after", int'(ovr_w[1]), 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    chk("merge_len_h", seq_h.size(), 2);
    chk("merge_len_l", seq_l.size(), 2);
    if (seq_h.size() == 2) begin
      chk("merge_h0", seq_h[0], 3);
      chk("merge_h1", seq_h[1], 1);
    end

    // Reset while presenting D2 with D3 pending
    drive(1'b0, 1'b1, 4'b0100, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 4'b1000, 1'b0);
    lit("pre_rst", 1, 1, 2);
    seq_l.delete();
    seq_h.delete();
    drive(1'b1, 1'b0, 4'b0000, 1'b0);
    lit("mid_rst", 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 1'b1);
      lit("after_rst", 1, 0, 0);
    end
    chk("after_rst_emits_h", seq_h.size(), 0);
    chk("after_rst_emits_l", seq_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prio_enc_4to2_hs.md
Name: prio_enc_4to2_hs

Overview:
Registered 4-to-2 priority encoder with event buffering and valid/ready output handshake. It is the reverse of the 2-to-4 enable decoder. Event lines D0..D3 are captured into a pending register. The highest-priority pending line is presented as a 2-bit code (A1,A0) with VALID and is retired when the consumer asserts RDY. Encoding the code back through the 2-to-4 decoder with EN=1 reproduces the originating line.

Parameters:
PRIO_HIGH, 1, 1 = D3 highest priority (D3>D2>D1>D0); 0 = D0 highest (D0>D1>D2>D3)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
EN  in  1  capture enable; D0..D3 ignored when 0
D0  in  1  event line, index 0
D1  in  1  event line, index 1
D2  in  1  event line, index 2
D3  in  1  event line, index 3
RDY  in  1  consumer accepts the presented code this cycle
A0  out  1  code bit 0 (index LSB)
A1  out  1  code bit 1 (index MSB)
VALID  out  1  code on A1,A0 is valid
OVR  out  1  overrun pulse (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-handshake):
  - pend=4'b0000, A1=A0=0, VALID=0, OVR=0, state=IDLE.
  - All pending and presented events are discarded.
- Capture, every edge: pend_next = (pend & ~clr_mask) | (EN ? {D3,D2,D1,D0} : 0).
  - A set on a bit wins over a clear on the same bit in the same cycle; the new event is kept.
  - A repeat event on an already-set pend bit merges into that bit (counted once).
- Selection:
  - sel = highest-priority set bit of the registered pend, per PRIO_HIGH.
  - Code = binary index: D0→00, D1→01, D2→10, D3→11.
- FSM states: IDLE, HOLD.
  - IDLE, pend!=0: load A1,A0=code(sel); VALID←1; clr_mask=onehot(sel); →HOLD.
  - IDLE, pend==0: stay; VALID=0.
  - HOLD, RDY=0: A1,A0,VALID held stable (no change while VALID=1 and RDY=0); clr_mask=0.
  - HOLD, RDY=1, pend!=0: back-to-back; load next code(sel), clr that bit, VALID stays 1, stay HOLD.
  - HOLD, RDY=1, pend==0: VALID←0, →IDLE; A1,A0 keep the last value.
- RDY while VALID=0 is ignored.
- Latency: D high with EN=1 before edge n → pend set after edge n → VALID=1 after edge n+1 (2 cycles).
- Throughput: 1 code per cycle when RDY is held high.
- EN=0 blocks capture only; already-pending events still drain.
- The presented event is removed from pend at load time, so a new event on the same line while it is presented re-pends it and it is presented again later.

Optional Feature:
Macro: PRIO_ENC_OVERRUN_EN
- Defined:
  - OVR=1 for exactly one cycle after any edge where EN=1, Dk=1 and pend[k] was already 1 (event lost by merge).
  - Simultaneous overruns on several lines produce a single pulse.
- Undefined: OVR tied to 0; no overrun logic synthesised; the port remains.

Decomposition:
- Package prio_enc_pkg:
  - state enum {IDLE, HOLD}
  - localparam N_LINES=4, CODE_W=2
  - function onehot(code)
- Sub-module prio_enc4 (combinational):
  - inputs pend[3:0], PRIO_HIGH
  - outputs code[1:0], any
  - reused for selection in both FSM states.

Test Plan:
1. rst=1 for 2 cycles with D3=1, EN=1 → A1A0=00, VALID=0, OVR=0; release with D=0 → VALID stays 0.
2. EN=1, D2 pulse 1 cycle, RDY=0 → VALID=1 two edges later, A1A0=10, held stable 5 cycles; RDY=1 for one cycle → VALID=0 next cycle.
3. EN=1, D0,D1,D3 pulsed together, RDY=1 constant, PRIO_HIGH=1 → codes 11,01,00 on consecutive cycles, then VALID=0; repeat with PRIO_HIGH=0 → 00,01,11.
4. EN=0, D0..D3=1111 for 3 cycles → VALID never asserts; then EN=1 one cycle with D1 → code 01.
5. D1 pulse, D1 pulsed again while pend[1]=1 → one code 01 only; with PRIO_ENC_OVERRUN_EN, OVR=1 one cycle after the second pulse edge; without it, OVR=0.
6. VALID=1 with code 10 and D3 pending, assert rst → next cycle VALID=0, pend cleared, no code 11 ever emitted.
